// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen control blocks.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        IC_IDLE     = 2'd0,
        IC_COALESCE = 2'd1,
        IC_ASSERT   = 2'd2,
        IC_CLEAR    = 2'd3
    } rggen_interrupt_coalescer_state_e;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rggen_popcount.sv
// Number of set bits in a vector, purely combinational.
module rggen_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           i_bits,
    output logic [$clog2(WIDTH+1)-1:0] o_count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Ripple sum of every bit; WIDTH is small, so a plain adder chain is fine.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/rggen_interrupt_coalescer.sv
// Coalesces rising rwc status bits into one level interrupt and, on
// acknowledge, optionally pulses the rwc fields' clear input.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IC_IDLE     | nothing pending; waits for any enabled status bit
// IC_COALESCE | gathering events until THRESHOLD or TIMEOUT is reached
// IC_ASSERT   | o_irq high, waiting for software acknowledge
// IC_CLEAR    | one-cycle o_clear pulse back into the rwc fields
module rggen_interrupt_coalescer
    import rggen_rtl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 4,
    parameter int TIMEOUT    = 16,
    parameter bit AUTO_CLEAR = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_status,
    input  logic [WIDTH-1:0] i_enable,
    input  logic             i_ack,
    output logic             o_irq,
    output logic             o_clear
);

    localparam int CNT_W = $clog2(THRESHOLD + 1);
    localparam int TMR_W = clog2_min1(TIMEOUT);
    localparam int NEW_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > NEW_W) ? CNT_W : NEW_W) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0] TH_SUM   = SUM_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(THRESHOLD);

    rggen_interrupt_coalescer_state_e state_q, state_d;

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] masked_q;
    logic             active;
    logic [NEW_W-1:0] new_events;
    logic [SUM_W-1:0] new_sum;
    logic [SUM_W-1:0] acc_sum;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q;
    logic             clear_q;

    assign masked  = i_status & i_enable;
    assign active  = |masked;
    assign new_sum = SUM_W'(new_events);
    assign acc_sum = SUM_W'(count_q) + new_sum;

    // A newly enabled, already-set bit also shows up as a rising edge here.
    rggen_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .i_bits  (masked & ~masked_q),
        .o_count (new_events)
    );

    // Next state, coalescing timer and saturating event count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        unique case (state_q)
            IC_IDLE: begin
                if (active) begin
                    timer_d = '0;
                    count_d = (new_sum >= TH_SUM) ? CNT_MAX : CNT_W'(new_events);
                    state_d = (new_sum >= TH_SUM) ? IC_ASSERT : IC_COALESCE;
                end
            end
            IC_COALESCE: begin
                timer_d = timer_q + TMR_W'(1);
                count_d = (acc_sum >= TH_SUM) ? CNT_MAX : CNT_W'(acc_sum);
                // Threshold/timeout take priority over software clearing everything.
                if ((acc_sum >= TH_SUM) || (timer_q == TMR_LAST)) begin
                    state_d = IC_ASSERT;
                end else if (!active) begin
                    state_d = IC_IDLE;
                end
            end
            IC_ASSERT: begin
                if (i_ack) begin
                    state_d = AUTO_CLEAR ? IC_CLEAR : IC_IDLE;
                end else if (!active) begin
                    state_d = IC_IDLE;
                end
            end
            IC_CLEAR: begin
                state_d = IC_IDLE;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    // State, history and registered outputs; reset wins in any state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IC_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            masked_q <= '0;
            irq_q    <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            masked_q <= masked;
            irq_q    <= (state_d == IC_ASSERT);
            clear_q  <= (state_d == IC_CLEAR);
        end
    end

    assign o_irq   = irq_q;
    assign o_clear = clear_q;

endmodule

// File: tb/tb_rggen_interrupt_coalescer.sv
// Bench for rggen_interrupt_coalescer: one auto-clearing and one plain
// instance, each fed by a modelled rwc status register, checked every cycle
// against an event-level reference model plus hand-computed milestones.
module tb_rggen_interrupt_coalescer;

    localparam int W  = 8;
    localparam int TH = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] en;
    logic [W-1:0] stat_a;
    logic [W-1:0] stat_b;
    logic         ack;
    logic         a_irq, a_clr, b_irq, b_clr;

    always #5 clk = ~clk;

    rggen_interrupt_coalescer #(
        .WIDTH(W), .THRESHOLD(TH), .TIMEOUT(TO), .AUTO_CLEAR(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_status(stat_a), .i_enable(en),
        .i_ack(ack), .o_irq(a_irq), .o_clear(a_clr)
    );

    rggen_interrupt_coalescer #(
        .WIDTH(W), .THRESHOLD(TH), .TIMEOUT(TO), .AUTO_CLEAR(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_status(stat_b), .i_enable(en),
        .i_ack(ack), .o_irq(b_irq), .o_clear(b_clr)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Reference model, per instance (0 = auto-clear, 1 = plain).
    bit           m_irq   [2] = '{0, 0};
    bit           m_clr   [2] = '{0, 0};
    bit           m_coal  [2] = '{0, 0};
    bit           clr_was [2] = '{0, 0};
    int           m_events[2] = '{0, 0};
    int           m_start [2] = '{0, 0};
    logic [W-1:0] m_prev  [2] = '{'0, '0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Advance the model over the cycle whose inputs were just sampled.
    task automatic step_model(input int i, input logic [W-1:0] masked, input bit ack_in, input bit rst_in);
        int  newe;
        bit  act;
        newe       = $countones(masked & ~m_prev[i]);
        act        = (masked != '0);
        clr_was[i] = m_clr[i];
        if (rst_in) begin
            m_irq[i] = 0; m_clr[i] = 0; m_coal[i] = 0; m_events[i] = 0;
            m_prev[i] = '0;
            return;
        end
        if (m_clr[i]) begin
            m_clr[i] = 0;
        end else if (m_irq[i]) begin
            if (ack_in) begin
                m_irq[i] = 0;
                m_clr[i] = (i == 0);
            end else if (!act) begin
                m_irq[i] = 0;
            end
        end else if (m_coal[i]) begin
            if ((m_events[i] + newe >= TH) || (cyc - m_start[i] == TO - 1)) begin
                m_coal[i] = 0;
                m_irq[i]  = 1;
            end else if (!act) begin
                m_coal[i] = 0;
            end else begin
                m_events[i] = m_events[i] + newe;
            end
        end else if (act) begin
            if (newe >= TH) begin
                m_irq[i] = 1;
            end else begin
                m_coal[i]   = 1;
                m_start[i]  = cyc + 1;
                m_events[i] = newe;
            end
        end
        m_prev[i] = masked;
    endtask

    // One clock: rwc fields apply last cycle's clear, software clears and
    // hardware sets; the DUTs sample; the model follows.
    task automatic tick(input logic [W-1:0] hw, input logic [W-1:0] swc,
                        input logic [W-1:0] en_in, input bit ack_in, input bit rst_in);
        stat_a = ((clr_was[0] ? '0 : stat_a) & ~swc) | hw;
        stat_b = ((clr_was[1] ? '0 : stat_b) & ~swc) | hw;
        en     = en_in;
        ack    = ack_in;
        rst    = rst_in;
        @(posedge clk);
        step_model(0, stat_a & en_in, ack_in, rst_in);
        step_model(1, stat_b & en_in, ack_in, rst_in);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        tick('0, '1, 8'hFF, 1'b0, 1'b1);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_irq", 32'(a_irq), 32'(m_irq[0]));
            check("a_clr", 32'(a_clr), 32'(m_clr[0]));
            check("b_irq", 32'(b_irq), 32'(m_irq[1]));
            check("b_clr", 32'(b_clr), 32'(m_clr[1]));
        end
    end

    initial begin
        logic [W-1:0] hw, swc, en_r;
        bit           ack_r, rst_r;
        int           irq_seen;

        stat_a = '0; stat_b = '0; en = '0; ack = 1'b0; rst = 1'b1;
        do_reset();
        chk_en = 1'b1;
        check("reset_irq", 32'(a_irq), 32'd0);
        check("reset_clr", 32'(a_clr), 32'd0);

        // Single event, timeout path; plain instance re-coalesces after ack.
        // After tick(c) the outputs shown belong to cycle c+1.
        for (int c = 0; c < 40; c++) begin
            hw = (c == 0) ? 8'h01 : 8'h00;
            tick(hw, '0, 8'hFF, c == 20, 1'b0);
            if (c == 15) check("s1_irq_c16", 32'(a_irq), 32'd0);
            if (c == 16) check("s1_irq_c17", 32'(a_irq), 32'd1);
            if (c == 20) begin
                check("s1_irq_c21", 32'(a_irq), 32'd0);
                check("s1_clr_c21", 32'(a_clr), 32'd1);
                check("s1_b_irq_c21", 32'(b_irq), 32'd0);
            end
            if (c == 21) check("s1_clr_c22", 32'(a_clr), 32'd0);
            if (c == 36) check("s1_b_irq_c37", 32'(b_irq), 32'd0);
            if (c == 37) check("s1_b_irq_c38", 32'(b_irq), 32'd1);
        end

        // Threshold reached in a single cycle.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            hw = (c == 0) ? 8'h0F : 8'h00;
            tick(hw, '0, 8'hFF, c == 3, 1'b0);
            if (c == 0) check("s2_irq_c1", 32'(a_irq), 32'd1);
            if (c == 3) check("s2_clr_c4", 32'(a_clr), 32'd1);
        end

        // Four spaced events beat the timeout.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            hw = '0;
            if (c <= 6 && (c % 2) == 0) hw[c/2] = 1'b1;
            tick(hw, '0, 8'hFF, 1'b0, 1'b0);
            if (c == 5) check("s3_irq_c6", 32'(a_irq), 32'd0);
            if (c == 6) check("s3_irq_c7", 32'(a_irq), 32'd1);
        end

        // Enabling already-set bits counts them: four at once assert directly.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            hw   = (c == 0) ? 8'h0F : 8'h00;
            en_r = (c < 10) ? 8'h00 : 8'h0F;
            tick(hw, '0, en_r, 1'b0, 1'b0);
            if (c == 9)  check("s4b_irq_c10", 32'(a_irq), 32'd0);
            if (c == 10) check("s4b_irq_c11", 32'(a_irq), 32'd1);
        end

        // Late enable of one bit, then software clears mid-coalesce.
        do_reset();
        irq_seen = 0;
        for (int c = 0; c < 40; c++) begin
            hw   = (c == 0) ? 8'h01 : 8'h00;
            en_r = (c < 10) ? 8'h00 : 8'h01;
            swc  = (c == 13) ? 8'hFF : 8'h00;
            tick(hw, swc, en_r, 1'b0, 1'b0);
            if (a_irq === 1'b1 || b_irq === 1'b1) irq_seen++;
        end
        check("s4_irq_never", 32'(irq_seen), 32'd0);

        // Reset while asserted and while clearing.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            hw = (c == 0) ? 8'h01 : 8'h00;
            tick(hw, '0, 8'hFF, c == 36, (c == 18) || (c == 37));
            if (c == 16) check("s6_irq_c17", 32'(a_irq), 32'd1);
            if (c == 18) begin
                check("s6_irq_c19", 32'(a_irq), 32'd0);
                check("s6_clr_c19", 32'(a_clr), 32'd0);
            end
            if (c == 34) check("s6_irq_c35", 32'(a_irq), 32'd0);
            if (c == 35) check("s6_irq_c36", 32'(a_irq), 32'd1);
            if (c == 36) check("s6_clr_c37", 32'(a_clr), 32'd1);
            if (c == 37) begin
                check("s6_clr_c38", 32'(a_clr), 32'd0);
                check("s6_irq_c38", 32'(a_irq), 32'd0);
            end
        end

        // Randomized traffic.
        en_r = 8'hFF;
        for (int c = 0; c < 3000; c++) begin
            hw = '0;
            if ($urandom_range(0, 6) == 0) hw[$urandom_range(0, W-1)] = 1'b1;
            if ($urandom_range(0, 40) == 0) hw = W'($urandom);
            swc = ($urandom_range(0, 25) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 80) == 0) en_r = W'($urandom);
            ack_r = ($urandom_range(0, 5) == 0);
            rst_r = ($urandom_range(0, 400) == 0);
            tick(hw, swc, en_r, ack_r, rst_r);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rggen_interrupt_coalescer.md
# rggen_interrupt_coalescer

Downstream consumer of a group of write-1/clear (rwc) status bit fields: watches their WIDTH-bit value together with an enable mask, counts newly raised status bits, and raises a level interrupt once either THRESHOLD events have accumulated or TIMEOUT cycles have passed since the first one. On software acknowledge it can optionally issue a one-cycle clear pulse back into the rwc fields' clear input, closing the loop between status register and interrupt line.

## Interface
- WIDTH, 8, number of status bits observed
- THRESHOLD, 4, event count that forces immediate assertion (>= 1)
- TIMEOUT, 16, max cycles spent coalescing before assertion (>= 1)
- AUTO_CLEAR, 1, 1: acknowledge emits o_clear pulse; 0: acknowledge only returns to idle
- i_clk  input  1  clock; all logic on its rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_status  input  WIDTH  status value from rwc fields (their o_value)
- i_enable  input  WIDTH  per-bit interrupt enable
- i_ack  input  1  software acknowledge, single-cycle pulse
- o_irq  output  1  interrupt request, registered
- o_clear  output  1  clear pulse to rwc fields' i_clear, registered

## Operation
- masked = i_status & i_enable; active = |masked; masked_q = masked registered each cycle.
- new_events = popcount(masked & ~masked_q); enabling an already-set bit counts as an event.
- event_count saturates at THRESHOLD, width $clog2(THRESHOLD+1); timer width $clog2(TIMEOUT), max value TIMEOUT-1.
- States: IDLE, COALESCE, ASSERT, CLEAR. o_irq = (state == ASSERT); o_clear = (state == CLEAR).
- IDLE: if active and new_events >= THRESHOLD -> ASSERT; else if active -> COALESCE, timer=0, event_count=new_events. Level-triggered: still-set status re-enters COALESCE.
- COALESCE: event_count += new_events (saturating); timer++. -> ASSERT if event_count+new_events >= THRESHOLD or timer == TIMEOUT-1; -> IDLE if !active (software cleared everything); threshold/timeout win over !active in the same cycle.
- ASSERT: i_ack -> CLEAR if AUTO_CLEAR, else IDLE. !active without i_ack -> IDLE. i_ack and !active together: i_ack rules apply.
- CLEAR: exactly one cycle, then IDLE unconditionally; bits set during CLEAR are wiped by the rwc field and are not counted.
- i_ack outside ASSERT ignored.

## Timing
- Reset: state IDLE, timer 0, event_count 0, masked_q 0, o_irq 0, o_clear 0 from the edge where i_rst is sampled high; applies mid-operation in any state (pending o_clear dropped). Status already set after reset counts as events in the first cycle.
- Single event at cycle 0, no others: COALESCE cycles 1..TIMEOUT, o_irq high from cycle TIMEOUT+1.
- >= THRESHOLD events in one cycle from IDLE: o_irq high next cycle.
- i_ack at cycle n in ASSERT: o_irq low and o_clear high in n+1; rwc status 0 in n+2; IDLE in n+2.
- No combinational path from any input to o_irq/o_clear.

## Structure
- State enum rggen_interrupt_coalescer_state_e belongs in shared package rggen_rtl_pkg.
- One combinational sub-module rggen_popcount (parameter WIDTH, output $clog2(WIDTH+1) bits); rest in a single always_ff plus next-state logic.

## Test plan
- Enable 0xFF, set bit 0 at cycle 0 (TIMEOUT=16) -> o_irq rises at cycle 17; i_ack at 20 -> o_clear=1 at 21 only, o_irq=0 at 21.
- Set status 0x0F in one cycle (THRESHOLD=4) -> o_irq at cycle 1, no COALESCE cycles.
- Set bits 0,1,2,3 on cycles 0,2,4,6 -> event_count reaches 4 on cycle 6, o_irq at cycle 7 (< timeout).
- Status 0x01 with enable 0x00 for 10 cycles, then enable 0x01 -> counted as event, COALESCE next cycle; software clears status mid-COALESCE -> IDLE, o_irq never rises.
- AUTO_CLEAR=0, status held 0x01, ack -> IDLE then COALESCE again next cycle, o_clear never high.
- Assert i_rst during ASSERT and during CLEAR -> o_irq=0, o_clear=0 next cycle; status still set -> new COALESCE after reset release.
